// File: rtl/multicycle_vec_controller_if.sv
// Control bus between the multicycle vector controller and its datapath.
// The master side is the controller: it consumes the instruction field,
// ALU flags and the memory-ready handshake, and drives every datapath
// select and write strobe. The slave side is the datapath / memory.
//   Instr[19:0]  Instr[31:12] from the instruction register
//   ALUFlags     NZCV from the ALU
//   MemReady     memory completes the current access this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite, VecWrite, Done   strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, VecLane
interface multicycle_vec_controller_if #(
    parameter int LANE_W = 2
);
    logic [19:0]       Instr;
    logic [3:0]        ALUFlags;
    logic              MemReady;
    logic              PCWrite;
    logic              AdrSrc;
    logic              IRWrite;
    logic              MemWrite;
    logic              RegWrite;
    logic              VecWrite;
    logic              ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [3:0]        ALUControl;
    logic [1:0]        ResultSrc;
    logic [1:0]        ImmSrc;
    logic [1:0]        RegSrc;
    logic [LANE_W-1:0] VecLane;
    logic              Done;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, VecWrite,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc,
               VecLane, Done
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, VecWrite,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc,
               VecLane, Done
    );
endinterface

// File: rtl/multicycle_vec_controller.sv
// Multicycle ARM-style controller with a vector extension.
// A state machine sequences fetch, decode, execute, memory and writeback,
// waiting on MemReady in the memory states. Op=11 runs one ALU operation
// over VEC_LANES lanes, two cycles per lane (VEXEC then VECWB).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    controller side of multicycle_vec_controller_if (see interface)
module multicycle_vec_controller #(
    parameter int VEC_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_vec_controller_if.master  bus
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] VEXEC  = 4'd10;
    localparam logic [3:0] VECWB  = 4'd11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VEC_LANES - 1);

    logic [3:0]        state;
    logic [3:0]        state_n;
    logic [3:0]        flags;      // {N, Z, C, V}
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_n;

    // Instruction fields (bus.Instr bit k is Instr[k+12]).
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       sbit;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign cmd       = funct[4:1];
    assign sbit      = funct[0];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

    logic [3:0] dec_alc;
    logic       is_cmp;
    logic       cv_cmd;
    logic       rd_pc;
    logic       cond_ex;

    assign is_cmp = (cmd == 4'b1010);
    assign cv_cmd = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
    assign rd_pc  = (rd == 4'd15);

    always_comb begin
        case (cmd)
            4'b0100: dec_alc = ALU_ADD;
            4'b0010: dec_alc = ALU_SUB;
            4'b0000: dec_alc = ALU_AND;
            4'b1100: dec_alc = ALU_ORR;
            4'b0001: dec_alc = ALU_EOR;
            4'b1101: dec_alc = ALU_MOV;
            4'b1010: dec_alc = ALU_SUB;
            default: dec_alc = ALU_ADD;
        endcase
    end

    // ARM condition table; 1111 is treated as never.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~(c & ~z);
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = ~(~z & (n == v));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    logic       pcw;
    logic       adr;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       vw;
    logic       sa;
    logic [1:0] sb;
    logic [3:0] alc;
    logic [1:0] rs;
    logic       done;

    always_comb begin
        state_n = state;
        lane_n  = lane;
        pcw     = 1'b0;
        adr     = 1'b0;
        irw     = 1'b0;
        mw      = 1'b0;
        rw      = 1'b0;
        vw      = 1'b0;
        sa      = 1'b0;
        sb      = 2'b00;
        alc     = ALU_ADD;
        rs      = 2'b00;
        done    = 1'b0;
        case (state)
            FETCH: begin
                sa  = 1'b1;
                sb  = 2'b10;
                rs  = 2'b10;
                irw = bus.MemReady;
                pcw = bus.MemReady;
                if (bus.MemReady) state_n = DECODE;
            end
            DECODE: begin
                sa = 1'b1;
                sb = 2'b10;
                if (!cond_ex) begin
                    state_n = FETCH;
                    done    = 1'b1;
                end else begin
                    case (op)
                        2'b00:   state_n = funct[5] ? EXECI : EXECR;
                        2'b01:   state_n = MEMADR;
                        2'b10:   state_n = BRANCH;
                        default: begin
                            state_n = VEXEC;
                            lane_n  = '0;
                        end
                    endcase
                end
            end
            MEMADR: begin
                sb      = 2'b01;
                state_n = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr = 1'b1;
                if (bus.MemReady) state_n = MEMWB;
            end
            MEMWR: begin
                adr = 1'b1;
                mw  = 1'b1;
                if (bus.MemReady) begin
                    state_n = FETCH;
                    done    = 1'b1;
                end
            end
            MEMWB: begin
                rs      = 2'b01;
                pcw     = rd_pc;
                rw      = ~rd_pc;
                state_n = FETCH;
                done    = 1'b1;
            end
            EXECR: begin
                alc     = dec_alc;
                state_n = ALUWB;
            end
            EXECI: begin
                sb      = 2'b01;
                alc     = dec_alc;
                state_n = ALUWB;
            end
            ALUWB: begin
                // CMP writes nothing back, not even to the PC.
                pcw     = ~is_cmp & rd_pc;
                rw      = ~is_cmp & ~rd_pc;
                state_n = FETCH;
                done    = 1'b1;
            end
            BRANCH: begin
                sb      = 2'b01;
                rs      = 2'b10;
                pcw     = 1'b1;
                state_n = FETCH;
                done    = 1'b1;
            end
            VEXEC: begin
                alc     = dec_alc;
                state_n = VECWB;
            end
            VECWB: begin
                vw = 1'b1;
                if (lane == LAST_LANE) begin
                    lane_n  = '0;
                    state_n = FETCH;
                    done    = 1'b1;
                end else begin
                    lane_n  = lane + LANE_W'(1);
                    state_n = VEXEC;
                end
            end
            default: begin
                state_n = FETCH;
                lane_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            flags <= '0;
            lane  <= '0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            if (state == EXECR || state == EXECI) begin
                if (sbit)          flags[3:2] <= bus.ALUFlags[3:2];
                if (sbit & cv_cmd) flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // Strobes are held low for as long as reset is asserted.
    assign bus.PCWrite    = pcw  & reset;
    assign bus.IRWrite    = irw  & reset;
    assign bus.MemWrite   = mw   & reset;
    assign bus.RegWrite   = rw   & reset;
    assign bus.VecWrite   = vw   & reset;
    assign bus.Done       = done & reset;
    assign bus.AdrSrc     = adr;
    assign bus.ALUSrcA    = sa;
    assign bus.ALUSrcB    = sb;
    assign bus.ALUControl = alc;
    assign bus.ResultSrc  = rs;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign bus.VecLane    = lane;

endmodule
